// File: rtl/dump_pkg.sv
// Shared constants and FSM encoding for the debug dump receiver.
// Optional checksum byte is enabled with DUMP_CHECKSUM_EN (see debug_dump_receiver).
package dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int REG_WORDS      = 32;
  localparam int MEM_WORDS      = 32;
  localparam int FRAME_BYTES    = BYTES_PER_WORD * (1 + REG_WORDS + MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_PC = 3'd1,
    S_RX_REGS = 3'd2,
    S_RX_MEM  = 3'd3,
    S_RX_CSUM = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/dump_word_assembler.sv
// Collects little-endian bytes into words; o_word_valid pulses for one cycle
// after the last byte of each word has been accepted.
module dump_word_assembler
  import dump_pkg::*;
#(
  parameter int BYTE = 8
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_clear,
  input  logic [BYTE-1:0]                i_byte,
  input  logic                           i_valid,
  output logic [BYTES_PER_WORD*BYTE-1:0] o_word,
  output logic                           o_word_valid
);

  localparam int SW = (BYTES_PER_WORD - 1) * BYTE;

  logic [1:0]    r_cnt;
  logic [SW-1:0] r_shift;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_valid) begin
        if (r_cnt == 2'(BYTES_PER_WORD - 1)) begin
          o_word       <= {i_byte, r_shift};
          o_word_valid <= 1'b1;
          r_cnt        <= '0;
        end else begin
          // earlier bytes shift down so the first byte ends up least significant
          r_shift <= {i_byte, r_shift[SW-1:BYTE]};
          r_cnt   <= r_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_dump_receiver.sv
// Receives the post-halt debug dump (PC, register bank, data memory) and keeps a
// readable snapshot. Define DUMP_CHECKSUM_EN for the trailing XOR checksum byte.
module debug_dump_receiver
  import dump_pkg::*;
#(
  parameter int BYTE           = 8,
  parameter int DWORD          = 32,
  parameter int READ_SIZE      = 5,
  parameter int ADDR           = 5,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                           i_clock,
  input  logic                                           i_reset,
  input  logic [BYTE-1:0]                                i_rx_data,
  input  logic                                           i_rx_done,
  input  logic                                           i_start,
  input  logic                                           i_rd_sel,
  input  logic [((READ_SIZE > ADDR) ? READ_SIZE : ADDR)-1:0] i_rd_addr,
  output logic [DWORD-1:0]                               o_rd_data,
  output logic [DWORD-1:0]                               o_pc,
  output logic                                           o_busy,
  output logic                                           o_frame_valid,
  output logic                                           o_error,
  output logic [2:0]                                     o_state
);

  localparam int MAXW = (READ_SIZE > ADDR) ? READ_SIZE : ADDR;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [MAXW-1:0] LAST_REG = MAXW'((1 << READ_SIZE) - 1);
  localparam logic [MAXW-1:0] LAST_MEM = MAXW'((1 << ADDR) - 1);

  state_t          r_state;
  logic [MAXW-1:0] r_widx;
  logic [TW-1:0]   r_tmo;
  logic [DWORD-1:0] r_ram [2**(MAXW+1)];
`ifdef DUMP_CHECKSUM_EN
  logic [BYTE-1:0] r_csum;
`endif

  logic [DWORD-1:0] w_word;
  logic             w_word_valid;
  logic             w_in_rx;
  logic             w_we;
  logic [MAXW-1:0]  w_rd_idx;

  assign w_in_rx  = (r_state == S_WAIT_PC) || (r_state == S_RX_REGS) || (r_state == S_RX_MEM);
  assign w_we     = w_word_valid && ((r_state == S_RX_REGS) || (r_state == S_RX_MEM));
  assign w_rd_idx = i_rd_addr & (i_rd_sel ? LAST_MEM : LAST_REG);
  assign o_state  = r_state;

  dump_word_assembler #(.BYTE(BYTE)) u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (r_state == S_IDLE),
    .i_byte       (i_rx_data),
    .i_valid      (i_rx_done && w_in_rx),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clock) begin
    if (w_we) r_ram[{r_state == S_RX_MEM, r_widx}] <= w_word;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) o_rd_data <= '0;
    else         o_rd_data <= r_ram[{i_rd_sel, w_rd_idx}];
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_widx        <= '0;
      r_tmo         <= '0;
      o_pc          <= '0;
      o_busy        <= 1'b0;
      o_frame_valid <= 1'b0;
      o_error       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      o_frame_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            o_error <= 1'b0;
            r_widx  <= '0;
            r_tmo   <= TW'(TIMEOUT_CYCLES);
            o_busy  <= 1'b1;
            r_state <= S_WAIT_PC;
`ifdef DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          if (i_rx_done)       r_tmo <= TW'(TIMEOUT_CYCLES);
          else if (r_tmo != 0) r_tmo <= r_tmo - 1'b1;
`ifdef DUMP_CHECKSUM_EN
          if (i_rx_done && w_in_rx) r_csum <= r_csum ^ i_rx_data;
`endif
          // terminal count with no byte arriving aborts the frame
          if (!i_rx_done && r_tmo == 0) begin
            o_error <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            case (r_state)
              S_WAIT_PC: if (w_word_valid) begin
                o_pc    <= w_word;
                r_widx  <= '0;
                r_state <= S_RX_REGS;
              end
              S_RX_REGS: if (w_word_valid) begin
                if (r_widx == LAST_REG) begin
                  r_widx  <= '0;
                  r_state <= S_RX_MEM;
                end else begin
                  r_widx <= r_widx + 1'b1;
                end
              end
              S_RX_MEM: if (w_word_valid) begin
                if (r_widx == LAST_MEM) begin
`ifdef DUMP_CHECKSUM_EN
                  r_state       <= S_RX_CSUM;
`else
                  r_state       <= S_DONE;
                  o_busy        <= 1'b0;
                  o_frame_valid <= 1'b1;
`endif
                end else begin
                  r_widx <= r_widx + 1'b1;
                end
              end
`ifdef DUMP_CHECKSUM_EN
              S_RX_CSUM: if (i_rx_done) begin
                if (i_rx_data != r_csum) o_error <= 1'b1;
                r_state       <= S_DONE;
                o_busy        <= 1'b0;
                o_frame_valid <= 1'b1;
              end
`endif
              default: begin
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
